// File: rtl/mem_timing_pkg.sv
// Shared types for the DDR4 bank timing tracker: bank state codes, decoded commands
// and the command-bus decoder.
package mem_timing_pkg;

  localparam int CNTW = 8;

  typedef enum logic [4:0] {
    ST_IDLE        = 5'b00000,
    ST_ACTIVATING  = 5'b00001,
    ST_ACTIVE      = 5'b00010,
    ST_PRECHARGING = 5'b01010,
    ST_READ        = 5'b01011,
    ST_RD_BURST    = 5'b01100,
    ST_WRITE       = 5'b10010,
    ST_WR_BURST    = 5'b10011
  } bank_state_e;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PRE,
    CMD_RD,
    CMD_WR
  } cmd_e;

  // rcw is {A16, A15, A14} = {ras_n, cas_n, we_n} when act_n is high
  function automatic cmd_e decode_cmd(input logic cs_n, input logic act_n,
                                      input logic [2:0] rcw);
    decode_cmd = CMD_NOP;
    if (!cs_n) begin
      if (!act_n) begin
        decode_cmd = CMD_ACT;
      end else begin
        case (rcw)
          3'b010:  decode_cmd = CMD_PRE;
          3'b101:  decode_cmd = CMD_RD;
          3'b100:  decode_cmd = CMD_WR;
          default: decode_cmd = CMD_NOP;
        endcase
      end
    end
  endfunction

endpackage

// File: rtl/mem_bank_timing_if.sv
// Command bus in, per-bank state/row and status pulses out.
interface mem_bank_timing_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17
);
  localparam int BANKGROUPS    = 2 ** BGWIDTH;
  localparam int BANKSPERGROUP = 2 ** BAWIDTH;

  logic                 cs_n;
  logic                 act_n;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic [ADDRWIDTH-1:0] A;
  logic                 stall;

  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] RowId;
  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0]           BankFSM;
  logic                 cmd_err;
  logic                 cmd_drop;

  modport master (
    output cs_n, act_n, bg, ba, A, stall,
    input  RowId, BankFSM, cmd_err, cmd_drop
  );

  modport slave (
    input  cs_n, act_n, bg, ba, A, stall,
    output RowId, BankFSM, cmd_err, cmd_drop
  );
endinterface

// File: rtl/mem_bank_fsm.sv
// One DDR4 bank: state code, timing down-counter, open row id and auto-precharge flag.
//  state          | meaning
//  IDLE           | bank closed
//  ACTIVATING     | row opening, TRCD cycles
//  ACTIVE         | row open, accepts RD/WR/PRE
//  PRECHARGING    | row closing, TRP cycles
//  READ / WRITE   | CAS latency, TCL / TCWL cycles
//  RD/WR_BURST    | data burst, TBURST cycles
module mem_bank_fsm
  import mem_timing_pkg::*;
#(
  parameter int ADDRWIDTH = 17,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TCL       = 5,
  parameter int TCWL      = 4,
  parameter int TBURST    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  cmd_e                 cmd,
  input  logic                 sel,
  input  logic                 all_sel,
  input  logic [ADDRWIDTH-1:0] a,
  input  logic                 stall,
  output bank_state_e          state,
  output logic [ADDRWIDTH-1:0] row_id,
  output logic                 err
);

  localparam logic [CNTW-1:0] LD_TRCD   = CNTW'(TRCD - 1);
  localparam logic [CNTW-1:0] LD_TRP    = CNTW'(TRP - 1);
  localparam logic [CNTW-1:0] LD_TCL    = CNTW'(TCL - 1);
  localparam logic [CNTW-1:0] LD_TCWL   = CNTW'(TCWL - 1);
  localparam logic [CNTW-1:0] LD_TBURST = CNTW'(TBURST - 1);

  logic [CNTW-1:0] cnt;
  logic            ap;
  logic            is_act;
  logic            is_pre;
  logic            is_rd;
  logic            is_wr;
  logic            illegal;

  // PRE-all never flags a busy bank; only a single-bank PRE can be illegal
  always_comb begin
    is_act  = sel && (cmd == CMD_ACT);
    is_pre  = (sel || all_sel) && (cmd == CMD_PRE);
    is_rd   = sel && (cmd == CMD_RD);
    is_wr   = sel && (cmd == CMD_WR);
    illegal = (is_act && (state != ST_IDLE))
           || ((is_rd || is_wr) && (state != ST_ACTIVE))
           || (is_pre && !all_sel && (state != ST_ACTIVE) && (state != ST_IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      row_id <= '0;
      ap     <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (!stall) begin
        err <= illegal;
        case (state)
          ST_IDLE: begin
            if (is_act) begin
              state  <= ST_ACTIVATING;
              cnt    <= LD_TRCD;
              row_id <= a;
            end
          end
          ST_ACTIVATING: begin
            if (cnt == '0) state <= ST_ACTIVE;
            else           cnt   <= cnt - CNTW'(1);
          end
          ST_ACTIVE: begin
            if (is_pre) begin
              state <= ST_PRECHARGING;
              cnt   <= LD_TRP;
            end else if (is_rd) begin
              state <= ST_READ;
              cnt   <= LD_TCL;
              ap    <= a[10];
            end else if (is_wr) begin
              state <= ST_WRITE;
              cnt   <= LD_TCWL;
              ap    <= a[10];
            end
          end
          ST_PRECHARGING: begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - CNTW'(1);
          end
          ST_READ: begin
            if (cnt == '0) begin
              state <= ST_RD_BURST;
              cnt   <= LD_TBURST;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          ST_WRITE: begin
            if (cnt == '0) begin
              state <= ST_WR_BURST;
              cnt   <= LD_TBURST;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          ST_RD_BURST, ST_WR_BURST: begin
            if (cnt == '0) begin
              if (ap) begin
                state <= ST_PRECHARGING;
                cnt   <= LD_TRP;
              end else begin
                state <= ST_ACTIVE;
              end
              ap <= 1'b0;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mem_bank_timing.sv
// Decodes the DDR4 command bus and tracks every bank's state and open row;
// the whole array freezes while the downstream stage stalls.
module mem_bank_timing
  import mem_timing_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TCL       = 5,
  parameter int TCWL      = 4,
  parameter int TBURST    = 4
) (
  input logic              clk,
  input logic              rst,
  mem_bank_timing_if.slave bus
);

  localparam int BANKGROUPS    = 2 ** BGWIDTH;
  localparam int BANKSPERGROUP = 2 ** BAWIDTH;

  cmd_e                 cmd;
  logic                 all_sel;
  logic                 drop;
  bank_state_e          st  [BANKGROUPS][BANKSPERGROUP];
  logic [ADDRWIDTH-1:0] row [BANKGROUPS][BANKSPERGROUP];
  logic                 err [BANKGROUPS][BANKSPERGROUP];

  assign cmd     = decode_cmd(bus.cs_n, bus.act_n, bus.A[16:14]);
  assign all_sel = (cmd == CMD_PRE) && bus.A[10];

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
      mem_bank_fsm #(
        .ADDRWIDTH (ADDRWIDTH),
        .TRCD      (TRCD),
        .TRP       (TRP),
        .TCL       (TCL),
        .TCWL      (TCWL),
        .TBURST    (TBURST)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd),
        .sel     ((bus.bg == BGWIDTH'(g)) && (bus.ba == BAWIDTH'(b))),
        .all_sel (all_sel),
        .a       (bus.A),
        .stall   (bus.stall),
        .state   (st[g][b]),
        .row_id  (row[g][b]),
        .err     (err[g][b])
      );
    end
  end

  // A stalled command is dropped rather than judged, so drop masks err by construction
  always_ff @(posedge clk) begin
    if (rst) drop <= 1'b0;
    else     drop <= bus.stall && (cmd != CMD_NOP);
  end

  always_comb begin
    bus.BankFSM = '0;
    bus.RowId   = '0;
    bus.cmd_err = 1'b0;
    for (int gi = 0; gi < BANKGROUPS; gi++) begin
      for (int bi = 0; bi < BANKSPERGROUP; bi++) begin
        bus.BankFSM[gi][bi] = st[gi][bi];
        bus.RowId[gi][bi]   = row[gi][bi];
        bus.cmd_err         = bus.cmd_err | err[gi][bi];
      end
    end
  end

  assign bus.cmd_drop = drop;

endmodule

// File: tb/tb_mem_bank_timing.sv
// Scoreboard bench for mem_bank_timing: expectations are queued as each command is
// driven and compared just after the clock edge that should produce them.
module tb_mem_bank_timing;

  localparam int BGWIDTH   = 2;
  localparam int BAWIDTH   = 2;
  localparam int ADDRWIDTH = 17;
  localparam int NG        = 4;
  localparam int NB        = 4;

  localparam logic [4:0] S_IDLE        = 5'b00000;
  localparam logic [4:0] S_ACTIVATING  = 5'b00001;
  localparam logic [4:0] S_ACTIVE      = 5'b00010;
  localparam logic [4:0] S_PRECHARGING = 5'b01010;
  localparam logic [4:0] S_READ        = 5'b01011;
  localparam logic [4:0] S_RD_BURST    = 5'b01100;
  localparam logic [4:0] S_WRITE       = 5'b10010;
  localparam logic [4:0] S_WR_BURST    = 5'b10011;

  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;

  localparam int K_STATE = 0;
  localparam int K_ROW   = 1;
  localparam int K_ERR   = 2;
  localparam int K_DROP  = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  string       tag_q[$];
  int          kind_q[$];
  int          g_q[$];
  int          b_q[$];
  logic [31:0] val_q[$];

  mem_bank_timing_if #(.BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ADDRWIDTH(ADDRWIDTH)) bus ();

  mem_bank_timing #(.BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ADDRWIDTH(ADDRWIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int g, input int b);
    case (kind)
      K_STATE: observe = 32'(bus.BankFSM[g][b]);
      K_ROW:   observe = 32'(bus.RowId[g][b]);
      K_ERR:   observe = 32'(bus.cmd_err);
      default: observe = 32'(bus.cmd_drop);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input int g, input int b,
                            input logic [31:0] v);
    tag_q.push_back(tag);
    kind_q.push_back(kind);
    g_q.push_back(g);
    b_q.push_back(b);
    val_q.push_back(v);
  endtask

  task automatic expect_all_reset(input string tag);
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < NB; b++) begin
        expect_val({tag, "_state"}, K_STATE, g, b, 32'(S_IDLE));
        expect_val({tag, "_row"},   K_ROW,   g, b, 32'h0);
      end
    end
    expect_val({tag, "_err"},  K_ERR,  0, 0, 32'h0);
    expect_val({tag, "_drop"}, K_DROP, 0, 0, 32'h0);
  endtask

  // One clock; everything queued for this edge is compared 1 ns after it
  task automatic cycle();
    @(posedge clk);
    #1;
    while (tag_q.size() > 0) begin
      check(tag_q.pop_front(),
            observe(kind_q.pop_front(), g_q.pop_front(), b_q.pop_front()),
            val_q.pop_front());
    end
  endtask

  task automatic drive_nop();
    bus.cs_n  = 1'b1;
    bus.act_n = 1'b1;
    bus.bg    = '0;
    bus.ba    = '0;
    bus.A     = '0;
  endtask

  task automatic drive_act(input int g, input int b, input logic [16:0] row);
    bus.cs_n  = 1'b0;
    bus.act_n = 1'b0;
    bus.bg    = 2'(g);
    bus.ba    = 2'(b);
    bus.A     = row;
  endtask

  task automatic drive_cmd(input int g, input int b, input logic [2:0] rcw, input logic a10);
    logic [16:0] a;
    a         = '0;
    a[16:14]  = rcw;
    a[10]     = a10;
    bus.cs_n  = 1'b0;
    bus.act_n = 1'b1;
    bus.bg    = 2'(g);
    bus.ba    = 2'(b);
    bus.A     = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    bus.stall = 1'b0;
    drive_nop();
    cycle();
    expect_all_reset("reset");
    cycle();
    rst = 1'b0;

    // ACT opens [1][2]; neighbours untouched
    drive_act(1, 2, 17'h1ABCD);
    expect_val("act_state", K_STATE, 1, 2, 32'(S_ACTIVATING));
    expect_val("act_row",   K_ROW,   1, 2, 32'h1ABCD);
    expect_val("act_other", K_STATE, 1, 1, 32'(S_IDLE));
    expect_val("act_row00", K_ROW,   0, 0, 32'h0);
    cycle();
    drive_nop();
    for (int i = 0; i < 3; i++) begin
      expect_val("trcd", K_STATE, 1, 2, 32'(S_ACTIVATING));
      cycle();
    end
    expect_val("trcd_done", K_STATE, 1, 2, 32'(S_ACTIVE));
    expect_val("act_noerr", K_ERR,   0, 0, 32'h0);
    cycle();

    // RD with auto-precharge; a single-bank PRE during READ is illegal
    drive_cmd(1, 2, RCW_RD, 1'b1);
    expect_val("rd_entry", K_STATE, 1, 2, 32'(S_READ));
    cycle();
    drive_cmd(1, 2, RCW_PRE, 1'b0);
    expect_val("pre_busy_state", K_STATE, 1, 2, 32'(S_READ));
    expect_val("pre_busy_err",   K_ERR,   0, 0, 32'h1);
    cycle();
    drive_nop();
    expect_val("pre_busy_pulse", K_ERR, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      expect_val("tcl", K_STATE, 1, 2, 32'(S_READ));
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      expect_val("rd_burst", K_STATE, 1, 2, 32'(S_RD_BURST));
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      expect_val("rd_ap_trp", K_STATE, 1, 2, 32'(S_PRECHARGING));
      cycle();
    end
    expect_val("rd_ap_idle", K_STATE, 1, 2, 32'(S_IDLE));
    expect_val("rd_ap_row",  K_ROW,   1, 2, 32'h1ABCD);
    cycle();

    // Reopen [1][2], then illegal ACT and WR, and a legal PRE to an idle bank
    drive_act(1, 2, 17'h1ABCD);
    cycle();
    drive_nop();
    for (int i = 0; i < 3; i++) cycle();
    expect_val("reopen", K_STATE, 1, 2, 32'(S_ACTIVE));
    cycle();
    drive_act(1, 2, 17'h00055);
    expect_val("act_active_err",   K_ERR,   0, 0, 32'h1);
    expect_val("act_active_state", K_STATE, 1, 2, 32'(S_ACTIVE));
    expect_val("act_active_row",   K_ROW,   1, 2, 32'h1ABCD);
    cycle();
    drive_cmd(0, 1, RCW_WR, 1'b0);
    expect_val("wr_idle_err",   K_ERR,   0, 0, 32'h1);
    expect_val("wr_idle_state", K_STATE, 0, 1, 32'(S_IDLE));
    cycle();
    drive_cmd(0, 2, RCW_PRE, 1'b0);
    expect_val("pre_idle_err",   K_ERR,   0, 0, 32'h0);
    expect_val("pre_idle_state", K_STATE, 0, 2, 32'(S_IDLE));
    cycle();

    // Stall during ACTIVATING; commands in the stall are dropped, drop beats err
    drive_act(3, 0, 17'h12345);
    expect_val("stall_act", K_STATE, 3, 0, 32'(S_ACTIVATING));
    cycle();
    drive_nop();
    expect_val("stall_pre1", K_STATE, 3, 0, 32'(S_ACTIVATING));
    cycle();
    bus.stall = 1'b1;
    drive_cmd(1, 2, RCW_WR, 1'b0);
    expect_val("drop_wr",       K_DROP,  0, 0, 32'h1);
    expect_val("drop_wr_err",   K_ERR,   0, 0, 32'h0);
    expect_val("drop_wr_state", K_STATE, 1, 2, 32'(S_ACTIVE));
    expect_val("stall_hold",    K_STATE, 3, 0, 32'(S_ACTIVATING));
    cycle();
    drive_act(1, 2, 17'h00077);
    expect_val("drop_act",      K_DROP, 0, 0, 32'h1);
    expect_val("drop_prio_err", K_ERR,  0, 0, 32'h0);
    expect_val("drop_act_row",  K_ROW,  1, 2, 32'h1ABCD);
    cycle();
    drive_nop();
    expect_val("drop_pulse", K_DROP,  0, 0, 32'h0);
    expect_val("stall_hold", K_STATE, 3, 0, 32'(S_ACTIVATING));
    cycle();
    bus.stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_val("stall_resume", K_STATE, 3, 0, 32'(S_ACTIVATING));
      cycle();
    end
    expect_val("stall_late_active", K_STATE, 3, 0, 32'(S_ACTIVE));
    cycle();

    // PRE-all with one bank mid-burst, then reset mid-burst
    drive_act(2, 3, 17'h0BEEF);
    cycle();
    drive_act(0, 0, 17'h00F0F);
    cycle();
    drive_nop();
    for (int i = 0; i < 3; i++) cycle();
    expect_val("open00", K_STATE, 0, 0, 32'(S_ACTIVE));
    expect_val("open23", K_STATE, 2, 3, 32'(S_ACTIVE));
    cycle();
    drive_cmd(2, 3, RCW_WR, 1'b0);
    expect_val("wr_entry", K_STATE, 2, 3, 32'(S_WRITE));
    cycle();
    drive_nop();
    for (int i = 0; i < 3; i++) begin
      expect_val("tcwl", K_STATE, 2, 3, 32'(S_WRITE));
      cycle();
    end
    expect_val("wr_burst", K_STATE, 2, 3, 32'(S_WR_BURST));
    cycle();
    drive_cmd(0, 0, RCW_PRE, 1'b1);
    expect_val("preall_00",    K_STATE, 0, 0, 32'(S_PRECHARGING));
    expect_val("preall_12",    K_STATE, 1, 2, 32'(S_PRECHARGING));
    expect_val("preall_30",    K_STATE, 3, 0, 32'(S_PRECHARGING));
    expect_val("preall_23",    K_STATE, 2, 3, 32'(S_WR_BURST));
    expect_val("preall_01",    K_STATE, 0, 1, 32'(S_IDLE));
    expect_val("preall_noerr", K_ERR,   0, 0, 32'h0);
    expect_val("preall_row12", K_ROW,   1, 2, 32'h1ABCD);
    cycle();
    drive_nop();
    expect_val("burst_cont", K_STATE, 2, 3, 32'(S_WR_BURST));
    expect_val("trp_cont",   K_STATE, 0, 0, 32'(S_PRECHARGING));
    cycle();
    rst = 1'b1;
    expect_all_reset("midrst");
    cycle();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
